// File: rtl/spinner_array_pkg.sv
// Shared definitions for the spinner array: accumulator width, clamp modes
// and the wrap/saturate fitting function.
package spinner_array_pkg;

   localparam int CLAMP_WRAP = 0;
   localparam int CLAMP_SAT  = 1;

   function automatic int acc_width(input int out_w, input int frac);
      return out_w + frac;
   endfunction

   // Folds a wide signed sum back into an acc_w-bit accumulator value.
   function automatic int fit_acc(input int sum, input int acc_w, input int mode);
      int top;
      top = (1 << acc_w) - 1;
      if (mode == CLAMP_SAT) begin
         if (sum < 0)
            return 0;
         if (sum > top)
            return top;
         return sum;
      end
      return sum & top;
   endfunction

endpackage

// File: rtl/spinner_channel.sv
// One spinner channel: digital step plus analog delta accumulation, position
// latched on the shared step event. Latency: spin_out updates the cycle after step.
module spinner_channel
   import spinner_array_pkg::*;
#(
   parameter int OUT_W    = 4,
   parameter int FRAC     = 3,
   parameter int STEP     = 4,
   parameter int FAST_MUL = 2,
   parameter int CLAMP    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             plus,
   input  logic             minus,
   input  logic             fast,
   input  logic [8:0]       spin_in,
   output logic [OUT_W-1:0] spin_out
);

   localparam int ACC_W = acc_width(OUT_W, FRAC);
   localparam int SUM_W = ACC_W + 2;
   localparam logic [ACC_W-1:0] ACC_RST =
      (CLAMP == CLAMP_SAT) ? ACC_W'(1 << (ACC_W - 1)) : '0;

   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        acc_nxt;
   logic                    tog_prev;
   logic                    ana_evt;
   logic signed [SUM_W-1:0] dig;
   logic signed [SUM_W-1:0] ana;
   logic signed [SUM_W-1:0] sum;

   assign ana_evt = spin_in[8] ^ tog_prev;

   always_comb begin
      dig = '0;
      if (step && (plus ^ minus)) begin
         if (fast)
            dig = SUM_W'(STEP * FAST_MUL);
         else
            dig = SUM_W'(STEP);
         if (minus)
            dig = -dig;
      end
      ana     = ana_evt ? SUM_W'(signed'(spin_in[7:0])) : '0;
      sum     = signed'({2'b00, acc}) + dig + ana;
      acc_nxt = ACC_W'(fit_acc(int'(sum), ACC_W, CLAMP));
   end

   // The toggle history follows spin_in even in reset so release is quiet.
   always_ff @(posedge clk) begin
      tog_prev <= spin_in[8];
      if (reset) begin
         acc      <= ACC_RST;
         spin_out <= ACC_RST[ACC_W-1:FRAC];
      end else begin
         acc <= acc_nxt;
         if (step)
            spin_out <= acc_nxt[ACC_W-1:FRAC];
      end
   end

endmodule

// File: rtl/spinner_array.sv
// Array of independent spinner channels sharing one strobe edge detector;
// valid pulses for one cycle alongside each spin_out update.
module spinner_array
   import spinner_array_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int OUT_W    = 4,
   parameter int FRAC     = 3,
   parameter int STEP     = 4,
   parameter int FAST_MUL = 2,
   parameter int CLAMP    = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      strobe,
   input  logic [CHANNELS-1:0]       plus,
   input  logic [CHANNELS-1:0]       minus,
   input  logic [CHANNELS-1:0]       fast,
   input  logic [CHANNELS*9-1:0]     spin_in,
   output logic [CHANNELS*OUT_W-1:0] spin_out,
   output logic                      valid
);

   logic strobe_prev;
   logic step;

   assign step = strobe & ~strobe_prev;

   // strobe_prev resets high so a strobe already high at release is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_prev <= 1'b1;
         valid       <= 1'b0;
      end else begin
         strobe_prev <= strobe;
         valid       <= step;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      spinner_channel #(
         .OUT_W    (OUT_W),
         .FRAC     (FRAC),
         .STEP     (STEP),
         .FAST_MUL (FAST_MUL),
         .CLAMP    (CLAMP)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .step     (step),
         .plus     (plus[c]),
         .minus    (minus[c]),
         .fast     (fast[c]),
         .spin_in  (spin_in[c*9 +: 9]),
         .spin_out (spin_out[c*OUT_W +: OUT_W])
      );
   end

endmodule

// File: tb/tb_spinner_array.sv
// Randomised and directed checks of spinner_array in wrap and saturate modes
// against an integer position model.
module tb_spinner_array;

   localparam int NCH   = 2;
   localparam int OW    = 4;
   localparam int ACCM  = 128;
   localparam int SLOW  = 4;
   localparam int QUICK = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            strobe = 1'b1;
   logic [NCH-1:0]  plus = '0;
   logic [NCH-1:0]  minus = '0;
   logic [NCH-1:0]  fast = '0;
   logic [NCH*9-1:0] spin_in = '0;
   logic [NCH*OW-1:0] out_w;
   logic [NCH*OW-1:0] out_s;
   logic            valid_w;
   logic            valid_s;

   int n_cmp = 0;
   int n_mis = 0;
   int vld_cnt = 0;

   // model state: index 0 = wrap instance, 1 = saturate instance
   int m_acc [2][NCH];
   int m_out [2][NCH];
   int m_valid;
   int m_prev_strobe;
   int m_prev_tog [NCH];

   always #5 clk = ~clk;

   spinner_array #(.CLAMP(0)) dut_w (
      .clk(clk), .reset(reset), .strobe(strobe), .plus(plus), .minus(minus),
      .fast(fast), .spin_in(spin_in), .spin_out(out_w), .valid(valid_w)
   );

   spinner_array #(.CLAMP(1)) dut_s (
      .clk(clk), .reset(reset), .strobe(strobe), .plus(plus), .minus(minus),
      .fast(fast), .spin_in(spin_in), .spin_out(out_s), .valid(valid_s)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int fit(input int a, input int sat);
      if (sat != 0)
         return (a < 0) ? 0 : ((a > ACCM - 1) ? ACCM - 1 : a);
      return ((a % ACCM) + ACCM) % ACCM;
   endfunction

   task automatic model_update();
      int stp, d, s;
      if (reset) begin
         m_prev_strobe = 1;
         m_valid = 0;
         for (int c = 0; c < NCH; c++) begin
            m_prev_tog[c] = int'(spin_in[c*9+8]);
            m_acc[0][c] = 0;
            m_acc[1][c] = ACCM / 2;
            m_out[0][c] = 0;
            m_out[1][c] = (ACCM / 2) / 8;
         end
         return;
      end
      stp = (strobe && m_prev_strobe == 0) ? 1 : 0;
      for (int c = 0; c < NCH; c++) begin
         d = 0;
         if (stp == 1 && (plus[c] != minus[c])) begin
            s = fast[c] ? QUICK : SLOW;
            d = plus[c] ? s : -s;
         end
         if (int'(spin_in[c*9+8]) != m_prev_tog[c])
            d += int'($signed(spin_in[c*9 +: 8]));
         m_prev_tog[c] = int'(spin_in[c*9+8]);
         for (int i = 0; i < 2; i++) begin
            m_acc[i][c] = fit(m_acc[i][c] + d, i);
            if (stp == 1)
               m_out[i][c] = m_acc[i][c] / 8;
         end
      end
      m_valid = stp;
      m_prev_strobe = int'(strobe);
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
      if (valid_w)
         vld_cnt++;
      for (int c = 0; c < NCH; c++) begin
         chk("wrap_out", int'(out_w[c*OW +: OW]), m_out[0][c]);
         chk("sat_out", int'(out_s[c*OW +: OW]), m_out[1][c]);
      end
      chk("wrap_valid", int'(valid_w), m_valid);
      chk("sat_valid", int'(valid_s), m_valid);
   endtask

   task automatic edge_step();
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
   endtask

   task automatic analog(input int c, input int delta);
      spin_in[c*9+8] = ~spin_in[c*9+8];
      spin_in[c*9 +: 8] = 8'(delta);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      strobe = 1'b1;
      plus = '0;
      minus = '0;
      fast = '0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();
      strobe = 1'b0;
      tick();
   endtask

   initial begin
      // reset with strobe held high, then release without an edge
      reset = 1'b1;
      strobe = 1'b1;
      repeat (3) tick();
      chk("rst_out_w", int'(out_w), 0);
      chk("rst_out_s", int'(out_s[3:0]), 8);
      chk("rst_valid", int'(valid_w), 0);
      reset = 1'b0;
      vld_cnt = 0;
      repeat (3) tick();
      chk("rst_release_no_valid", vld_cnt, 0);
      strobe = 1'b0;
      tick();

      // four slow steps on channel 0
      plus[0] = 1'b1;
      vld_cnt = 0;
      repeat (4) edge_step();
      chk("step_out", int'(out_w[3:0]), 2);
      chk("step_valid_cnt", vld_cnt, 4);
      chk("step_ch1", int'(out_w[7:4]), 0);

      // one fast step: 16 -> 24
      fast[0] = 1'b1;
      edge_step();
      chk("fast_out", int'(out_w[3:0]), 3);
      fast[0] = 1'b0;

      // wrap: 24 + 102 = 126, +1 = 127, +4 -> 131 mod 128 = 3
      analog(0, 102);
      tick();
      chk("wrap_hold", int'(out_w[3:0]), 3);
      analog(0, 1);
      tick();
      edge_step();
      chk("wrap_out", int'(out_w[3:0]), 0);
      plus[0] = 1'b0;

      // saturate: 64 - 128 -> 0, minus step stays 0, plus+minus unchanged
      do_reset();
      chk("clamp_rst", int'(out_s[3:0]), 8);
      analog(0, -128);
      tick();
      minus[0] = 1'b1;
      edge_step();
      chk("clamp_low", int'(out_s[3:0]), 0);
      plus[0] = 1'b1;
      edge_step();
      chk("clamp_both", int'(out_s[3:0]), 0);
      plus[0] = 1'b0;
      minus[0] = 1'b0;

      // simultaneous step and analog: 0 + 4 + 8 = 12
      do_reset();
      plus[0] = 1'b1;
      analog(0, 8);
      strobe = 1'b1;
      chk("simul_before", int'(out_w[3:0]), 0);
      tick();
      chk("simul_out", int'(out_w[3:0]), 1);
      chk("simul_valid", int'(valid_w), 1);
      strobe = 1'b0;
      plus[0] = 1'b0;
      tick();

      // random traffic, including occasional reset mid-event
      for (int n = 0; n < 400; n++) begin
         reset  = ($urandom_range(0, 49) == 0);
         strobe = 1'($urandom_range(0, 1));
         plus   = NCH'($urandom);
         minus  = NCH'($urandom);
         fast   = NCH'($urandom);
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 2) == 0)
               analog(c, int'($urandom_range(0, 127)) - 64);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
